pll_reset_sequencer: RTL

- Sequences reset and lock qualification of the transmitter system-clock PLL.
- Issues a minimum-width PLL reset, then waits for lock with a timeout and retries, then qualifies lock stability.
- Releases a downstream logic reset only after lock is stable. Re-sequences on loss of lock or software request.
- Sits in the 200 MHz input-clock domain, between the global reset and the PLL reset/locked pins.

---
 rtl/pll_reset_sequencer_pkg.sv | 28 ++
 rtl/pll_reset_sequencer_if.sv | 42 ++++
 rtl/pll_reset_sequencer_syn.sv | 29 ++
 rtl/pll_reset_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, widths
// and the saturating lock-loss counter helper.
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RST_ASSERT = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABILIZE  = 3'd2,
    READY      = 3'd3,
    FAIL       = 3'd4
  } pll_state_e;

  localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

  // Increment the lock-loss counter, holding at its ceiling.
  function automatic logic [7:0] loss_sat_inc(input logic [7:0] cnt);
    logic [7:0] result;
    if (cnt == LOSS_CNT_MAX) begin
      result = cnt;
    end else begin
      result = cnt + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings
// (PLL pins, software request, downstream reset and status).
interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic               pll_locked_in;
  logic               sw_reset_req;
  logic               pll_reset;
  logic               logic_reset;
  logic               sys_ready;
  logic               lock_fail;
  logic [3:0]         retry_count;
  logic [7:0]         lock_loss_count;
  logic [STATE_W-1:0] state_out;

  // The sequencer itself.
  modport master (
    input  pll_locked_in,
    input  sw_reset_req,
    output pll_reset,
    output logic_reset,
    output sys_ready,
    output lock_fail,
    output retry_count,
    output lock_loss_count,
    output state_out
  );

  // The PLL and the software/downstream side.
  modport slave (
    output pll_locked_in,
    output sw_reset_req,
    input  pll_reset,
    input  logic_reset,
    input  sys_ready,
    input  lock_fail,
    input  retry_count,
    input  lock_loss_count,
    input  state_out
  );

endinterface

// File: rtl/pll_reset_sequencer_syn.sv
// Two-flop synchronizer for a single asynchronous level signal.
module syn_block (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else if (en) begin
      meta_r <= d;
      sync_r <= meta_r;
    end else begin
      meta_r <= meta_r;
      sync_r <= sync_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout
// and bounded retries, qualifies lock stability, then releases the
// downstream logic reset. Re-sequences on lock loss or software request.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 200000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 18
) (
  input  logic                  clk,
  input  logic                  g_reset,
  pll_reset_sequencer_if.master bus
);

  // Terminal timer values: each timed state leaves on the cycle its timer
  // reaches these, so the shared timer never wraps.
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TIMER_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  pll_state_e       state_r;
  pll_state_e       state_nxt_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_nxt_s;
  logic [3:0]       retry_r;
  logic [3:0]       retry_nxt_s;
  logic [7:0]       loss_r;
  logic [7:0]       loss_nxt_s;

  logic             pll_reset_r;
  logic             logic_reset_r;
  logic             sys_ready_r;
  logic             lock_fail_r;
  logic             pll_reset_nxt_s;
  logic             logic_reset_nxt_s;
  logic             sys_ready_nxt_s;
  logic             lock_fail_nxt_s;

  logic             locked_s;

  syn_block u_lock_sync (
    .clk (clk),
    .rst (g_reset),
    .en  (1'b1),
    .d   (bus.pll_locked_in),
    .q   (locked_s)
  );

  // Next-state, timer and counter logic; a software request overrides
  // every other event in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    retry_nxt_s = retry_r;
    loss_nxt_s  = loss_r;
    if (bus.sw_reset_req) begin
      state_nxt_s = RST_ASSERT;
      timer_nxt_s = TIMER_ZERO;
      retry_nxt_s = 4'd0;
    end else begin
      case (state_r)
        RST_ASSERT: begin
          if (timer_r == PULSE_LAST) begin
            state_nxt_s = WAIT_LOCK;
            timer_nxt_s = TIMER_ZERO;
          end else begin
            timer_nxt_s = timer_r + TIMER_ONE;
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a timeout landing in the same cycle.
          if (locked_s) begin
            state_nxt_s = STABILIZE;
            timer_nxt_s = TIMER_ZERO;
          end else if (timer_r == TIMEOUT_LAST) begin
            timer_nxt_s = TIMER_ZERO;
            if (retry_r < RETRY_LIMIT) begin
              retry_nxt_s = retry_r + 4'd1;
              state_nxt_s = RST_ASSERT;
            end else begin
              state_nxt_s = FAIL;
            end
          end else begin
            timer_nxt_s = timer_r + TIMER_ONE;
          end
        end
        STABILIZE: begin
          // A lock glitch here restarts the lock wait without a retry.
          if (!locked_s) begin
            state_nxt_s = WAIT_LOCK;
            timer_nxt_s = TIMER_ZERO;
          end else if (timer_r == STABLE_LAST) begin
            state_nxt_s = READY;
            timer_nxt_s = TIMER_ZERO;
          end else begin
            timer_nxt_s = timer_r + TIMER_ONE;
          end
        end
        READY: begin
          if (!locked_s) begin
            loss_nxt_s  = loss_sat_inc(loss_r);
            retry_nxt_s = 4'd0;
            state_nxt_s = RST_ASSERT;
            timer_nxt_s = TIMER_ZERO;
          end else begin
            timer_nxt_s = TIMER_ZERO;
          end
        end
        FAIL: begin
          timer_nxt_s = TIMER_ZERO;
        end
        default: begin
          state_nxt_s = RST_ASSERT;
          timer_nxt_s = TIMER_ZERO;
          retry_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // Output values decoded from the next state so they register together
  // with the state itself.
  always_comb begin
    pll_reset_nxt_s   = 1'b1;
    logic_reset_nxt_s = 1'b1;
    sys_ready_nxt_s   = 1'b0;
    lock_fail_nxt_s   = 1'b0;
    case (state_nxt_s)
      RST_ASSERT: begin
        pll_reset_nxt_s = 1'b1;
      end
      WAIT_LOCK, STABILIZE: begin
        pll_reset_nxt_s = 1'b0;
      end
      READY: begin
        pll_reset_nxt_s   = 1'b0;
        logic_reset_nxt_s = 1'b0;
        sys_ready_nxt_s   = 1'b1;
      end
      FAIL: begin
        pll_reset_nxt_s = 1'b0;
        lock_fail_nxt_s = 1'b1;
      end
      default: begin
        pll_reset_nxt_s = 1'b1;
      end
    endcase
  end

  // State, timer and counter registers.
  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      state_r <= RST_ASSERT;
      timer_r <= TIMER_ZERO;
      retry_r <= 4'd0;
      loss_r  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
      retry_r <= retry_nxt_s;
      loss_r  <= loss_nxt_s;
    end
  end

  // Registered control and status outputs.
  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      pll_reset_r   <= 1'b1;
      logic_reset_r <= 1'b1;
      sys_ready_r   <= 1'b0;
      lock_fail_r   <= 1'b0;
    end else begin
      pll_reset_r   <= pll_reset_nxt_s;
      logic_reset_r <= logic_reset_nxt_s;
      sys_ready_r   <= sys_ready_nxt_s;
      lock_fail_r   <= lock_fail_nxt_s;
    end
  end

  assign bus.pll_reset       = pll_reset_r;
  assign bus.logic_reset     = logic_reset_r;
  assign bus.sys_ready       = sys_ready_r;
  assign bus.lock_fail       = lock_fail_r;
  assign bus.retry_count     = retry_r;
  assign bus.lock_loss_count = loss_r;
  assign bus.state_out       = state_r;

endmodule
